// File: rtl/i2s_transmitter.sv
// i2s_transmitter: mono I2S serializer with a one-sample holding buffer.
// The same latched sample is sent in both slots of every 64-bit frame, MSB first with the
// standard one-bit I2S delay. Build macro I2S_TX_UNDERRUN_EN adds the underrun pulse and a
// saturating underrun counter; without it those outputs are tied to zero.
module i2s_transmitter #(
  parameter int unsigned SCLK_DIV   = 16,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  sclk_out,
  output logic                  ws_out,
  output logic                  sdata_out,
  output logic                  underrun_out,
  output logic [15:0]           underrun_count_out
);

  localparam int unsigned     DivW    = $clog2(SCLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);
  // Left shift that places the sample MSB at slot bit 1 of a 32-bit slot word.
  localparam int unsigned     SlotPad = 31 - DATA_WIDTH;

  logic [DivW-1:0]       div_q, div_d;
  logic                  sclk_q, sclk_d;
  logic [5:0]            bit_q, bit_d;
  logic                  ws_q, ws_d;
  logic                  sdata_q, sdata_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  buf_full_q, buf_full_d;
  logic                  ready_q, ready_d;

  logic                  div_wrap;
  logic                  sclk_fall;
  logic                  frame_load;
  logic                  accept;
  logic [31:0]           slot_word;

  // Next-state for bit clock, frame position, holding buffer and serial outputs.
  always_comb begin
    div_wrap   = (div_q == DivLast);
    sclk_fall  = div_wrap & sclk_q;
    frame_load = sclk_fall & (bit_q == 6'd63);
    accept     = valid_in & ready_q;

    div_d  = div_wrap ? '0 : div_q + DivW'(1);
    sclk_d = sclk_q ^ div_wrap;
    bit_d  = sclk_fall ? bit_q + 6'd1 : bit_q;

    buf_d      = accept ? sample_in : buf_q;
    buf_full_d = buf_full_q;
    frame_d    = frame_q;
    // An empty buffer at frame start leaves the previous sample in the frame register.
    if (frame_load && buf_full_q) begin
      frame_d    = buf_q;
      buf_full_d = 1'b0;
    end
    // Accept only happens while the buffer is empty, so it never races a drain.
    if (accept) begin
      buf_full_d = 1'b1;
    end
    ready_d = ~buf_full_d;

    // Slot word bit 31 is slot bit 0, hence the inverted slot index below.
    slot_word = 32'({1'b0, frame_d}) << SlotPad;
    ws_d      = sclk_fall ? bit_d[5] : ws_q;
    sdata_d   = sclk_fall ? slot_word[~bit_d[4:0]] : sdata_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      bit_q      <= 6'd63;
      ws_q       <= 1'b0;
      sdata_q    <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      frame_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      bit_q      <= bit_d;
      ws_q       <= ws_d;
      sdata_q    <= sdata_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      frame_q    <= frame_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_out = ready_q;
  assign sclk_out  = sclk_q;
  assign ws_out    = ws_q;
  assign sdata_out = sdata_q;

`ifdef I2S_TX_UNDERRUN_EN
  logic        underrun_q;
  logic [15:0] ucount_q;

  // Flag a frame start that finds no fresh sample; the count sticks at all-ones.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else begin
      underrun_q <= frame_load & ~buf_full_q;
      if (frame_load && !buf_full_q && (ucount_q != 16'hFFFF)) begin
        ucount_q <= ucount_q + 16'd1;
      end
    end
  end

  assign underrun_out       = underrun_q;
  assign underrun_count_out = ucount_q;
`else
  assign underrun_out       = 1'b0;
  assign underrun_count_out = '0;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: two transmitters (SCLK_DIV 16 and 2) driven from shared stimulus,
// each checked every cycle against a timing model derived from cycle counts since reset,
// plus slot-word vectors and hand-written corner-case sequences on the SCLK_DIV=16 instance.
module tb_i2s_transmitter;

  localparam int unsigned DW        = 24;
  localparam int unsigned NI        = 2;
  localparam int unsigned FrameCyc0 = 64 * 2 * 16;
`ifdef I2S_TX_UNDERRUN_EN
  localparam int unsigned ExpUr = 3;
`else
  localparam int unsigned ExpUr = 0;
`endif

  typedef struct {
    logic [DW-1:0] sample;
    logic [31:0]   word;
  } vec_t;

  logic          clk_100mhz = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sample;
  logic          valid;
  logic [NI-1:0] ready, sclk, ws, sdata, urun;
  logic [15:0]   ucnt [NI];

  always #5 clk_100mhz = ~clk_100mhz;

  i2s_transmitter #(.SCLK_DIV(16), .DATA_WIDTH(DW)) u_dut_div16 (
    .clk_in             (clk_100mhz),
    .rst_in             (rst_n),
    .sample_in          (sample),
    .valid_in           (valid),
    .ready_out          (ready[0]),
    .sclk_out           (sclk[0]),
    .ws_out             (ws[0]),
    .sdata_out          (sdata[0]),
    .underrun_out       (urun[0]),
    .underrun_count_out (ucnt[0])
  );

  i2s_transmitter #(.SCLK_DIV(2), .DATA_WIDTH(DW)) u_dut_div2 (
    .clk_in             (clk_100mhz),
    .rst_in             (rst_n),
    .sample_in          (sample),
    .valid_in           (valid),
    .ready_out          (ready[1]),
    .sclk_out           (sclk[1]),
    .ws_out             (ws[1]),
    .sdata_out          (sdata[1]),
    .underrun_out       (urun[1]),
    .underrun_count_out (ucnt[1])
  );

  // Reference model: time since reset release plus buffer/frame contents.
  int unsigned   m_t     [NI];
  bit            m_full  [NI];
  logic [DW-1:0] m_buf   [NI];
  logic [DW-1:0] m_frame [NI];
  bit            m_ready [NI];
  bit            m_urun  [NI];
  logic [15:0]   m_ucnt  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  // Slot capture on the SCLK_DIV=16 instance.
  bit          prev_sclk0, prev_ws0, last_ws;
  logic [31:0] shift0, last_word;
  int unsigned words_seen = 0;

  function automatic int unsigned div_of(int k);
    return (k == 0) ? 16 : 2;
  endfunction

  function automatic logic [20:0] expect_outs(int k);
    int unsigned   d, nf, b, j;
    logic          e_sclk, e_ws, e_sd;
    logic [DW-1:0] tmp;
    d      = div_of(k);
    e_sclk = ((m_t[k] / d) % 2) == 1;
    nf     = m_t[k] / (2 * d);
    e_ws   = 1'b0;
    e_sd   = 1'b0;
    if (nf != 0) begin
      b    = (nf - 1) % 64;
      j    = b % 32;
      e_ws = (b >= 32);
      if (j >= 1 && j <= DW) begin
        tmp  = m_frame[k] >> (DW - j);
        e_sd = tmp[0];
      end
    end
    return {m_ready[k], e_sclk, e_ws, e_sd, m_urun[k], m_ucnt[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: advance model, then compare both instances and capture slot words.
  task automatic step();
    bit            acc [NI];
    bit            r;
    logic [DW-1:0] s;
    int unsigned   d2, nf;
    logic [20:0]   got;
    r = rst_n;
    s = sample;
    for (int k = 0; k < NI; k++) acc[k] = valid && m_ready[k];
    @(posedge clk_100mhz);
    for (int k = 0; k < NI; k++) begin
      if (!r) begin
        m_t[k] = 0; m_full[k] = 0; m_frame[k] = '0; m_ready[k] = 0;
        m_urun[k] = 0; m_ucnt[k] = '0;
      end else begin
        m_t[k]++;
        m_urun[k] = 0;
        d2 = 2 * div_of(k);
        if (m_t[k] % d2 == 0) begin
          nf = m_t[k] / d2;
          if ((nf - 1) % 64 == 0) begin
            if (m_full[k]) begin
              m_frame[k] = m_buf[k];
              m_full[k]  = 0;
            end else begin
`ifdef I2S_TX_UNDERRUN_EN
              m_urun[k] = 1;
              if (m_ucnt[k] != 16'hFFFF) m_ucnt[k] = m_ucnt[k] + 16'd1;
`endif
            end
          end
        end
        if (acc[k]) begin
          m_buf[k]  = s;
          m_full[k] = 1;
        end
        m_ready[k] = !m_full[k];
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      got = {ready[k], sclk[k], ws[k], sdata[k], urun[k], ucnt[k]};
      check((k == 0) ? "outs_div16" : "outs_div2", {11'b0, got}, {11'b0, expect_outs(k)});
    end
    if (!r) begin
      shift0 = '0; prev_ws0 = 0; prev_sclk0 = 0;
    end else begin
      if (prev_sclk0 && !sclk[0]) begin
        if (ws[0] != prev_ws0) begin
          last_word = shift0;
          last_ws   = prev_ws0;
          words_seen++;
        end
        shift0   = {shift0[30:0], sdata[0]};
        prev_ws0 = ws[0];
      end
      prev_sclk0 = sclk[0];
    end
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_word(input bit want_ws, output logic [31:0] word);
    int unsigned seen;
    seen = words_seen;
    for (int i = 0; i < 3 * FrameCyc0; i++) begin
      step();
      if (words_seen != seen && last_ws == want_ws) begin
        word = last_word;
        return;
      end
      seen = words_seen;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_word: no slot with ws=%0d ended, got none required one", want_ws);
    word = 32'hDEADBEEF;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3 * FrameCyc0; i++) begin
      if (ready[0]) return;
      step();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_ready: ready_out got 0 required 1 within budget");
  endtask

  initial begin
    vec_t        vecs [4];
    logic [31:0] w;
    int unsigned lowcnt, acc_cnt, ur;
    bit          a;

    // Slot word: bit 31 = slot bit 0 (always 0), then sample MSB first, then zero pad.
    vecs[0] = '{sample: 24'hFFFFFF, word: 32'h7FFFFF80};
    vecs[1] = '{sample: 24'h000001, word: 32'h00000080};
    vecs[2] = '{sample: 24'h123456, word: 32'h091A2B00};
    vecs[3] = '{sample: 24'h800001, word: 32'h40000080};

    valid  = 1'b0;
    sample = '0;
    rst_n  = 1'b0;
    run(3);

    // Idle after reset: all slots carry zeros.
    rst_n = 1'b1;
    run(2 * FrameCyc0 + 10);
    check("idle_word", last_word, 32'h0);

    // Accept just before the frame 0 load.
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    while (m_t[0] < 30) step();
    valid  = 1'b1;
    sample = 24'hA5A5A5;
    step();
    valid  = 1'b0;
    sample = 24'h0F0F0F;
    lowcnt = ready[0] ? 0 : 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!ready[0]) lowcnt++;
    end
    check("a5_ready_low_cycles", lowcnt, 1);
    wait_word(1'b0, w);
    check("a5_left", w, 32'h52D2D280);
    wait_word(1'b1, w);
    check("a5_right", w, 32'h52D2D280);

    // Table of samples and their serialized slot words.
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      valid  = 1'b1;
      sample = vecs[i].sample;
      step();
      valid  = 1'b0;
      sample = DW'($urandom);
      wait_word(1'b1, w);
      wait_word(1'b0, w);
      check($sformatf("vec%0d_left", i), w, vecs[i].word);
      wait_word(1'b1, w);
      check($sformatf("vec%0d_right", i), w, vecs[i].word);
    end

    // Streaming with valid held high and an incrementing sample.
    wait_ready();
    valid  = 1'b1;
    sample = 24'h100000;
    a = valid && ready[0];
    step();
    if (a) sample = sample + 1'b1;
    acc_cnt = 0;
    ur      = 0;
    for (int i = 0; i < 5 * FrameCyc0; i++) begin
      a = valid && ready[0];
      step();
      if (a) begin
        acc_cnt++;
        sample = sample + 1'b1;
      end
      if (urun[0]) ur++;
    end
    valid = 1'b0;
    check("stream_accepts", acc_cnt, 5);
    check("stream_underruns", ur, 0);

    // Random valid/sample traffic, checked by the model.
    for (int i = 0; i < 4 * FrameCyc0; i++) begin
      valid  = ($urandom_range(0, 3) == 0);
      sample = DW'($urandom);
      step();
    end
    valid = 1'b0;

    // One sample then starvation for three frames.
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    step();
    valid  = 1'b1;
    sample = 24'h800001;
    step();
    valid  = 1'b0;
    sample = 24'h7FFFFF;
    ur = 0;
    while (m_t[0] < 3 * FrameCyc0 + 40) begin
      step();
      if (urun[0]) ur++;
    end
    check("urun_pulses", ur, ExpUr);
    check("urun_count", {16'b0, ucnt[0]}, ExpUr);
    check("urun_repeat_word", last_word, 32'h40000080);

    // Reset at bit_cnt 40 with the buffer full.
    wait_ready();
    valid  = 1'b1;
    sample = 24'h5A5A5A;
    step();
    valid = 1'b0;
    for (int i = 0; i < 2 * FrameCyc0; i++) begin
      if (m_t[0] >= 32 && ((m_t[0] / 32 - 1) % 64) == 40) break;
      step();
    end
    check("rst_buf_full_ready", {31'b0, ready[0]}, 32'h0);
    rst_n = 1'b0;
    step();
    check("rst_outs", {11'b0, ready[0], sclk[0], ws[0], sdata[0], urun[0], ucnt[0]}, 32'h0);
    rst_n = 1'b1;
    wait_word(1'b0, w);
    check("rst_left", w, 32'h0);
    wait_word(1'b1, w);
    check("rst_right", w, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
